// File: rtl/fp_add_align.sv
// fp_add_align: orders two binary32 operands by magnitude and right-aligns the smaller
//   significand with guard/round/sticky collection.
// Ports: clk/rst, in_valid/in_ready + op_a/op_b/sub in; out_valid/out_ready + sign_a, sign_b,
//   eff_sub, swapped, exp_big, mant_big, mant_small, special out.
// Latency: 2 + ceil(diff/SHIFT_STEP) edges, with the accept edge counted. One pair in flight.
// Backpressure: in_ready is high only in IDLE. Outputs hold in DONE until out_ready.
module fp_add_align #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_a,
  output logic        sign_b,
  output logic        eff_sub,
  output logic        swapped,
  output logic [7:0]  exp_big,
  output logic [26:0] mant_big,
  output logic [26:0] mant_small,
  output logic        special
);

  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sub_q, sub_d;
  logic [4:0]  rem_q, rem_d;
  logic        sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic        eff_sub_q, eff_sub_d, swapped_q, swapped_d, special_q, special_d;
  logic [7:0]  exp_big_q, exp_big_d;
  logic [26:0] mant_big_q, mant_big_d, mant_small_q, mant_small_d;

  // Unpacked operands: a zero exponent field means a denormal or zero,
  // which uses effective exponent 1 and a clear hidden bit.
  logic [7:0]  ea, eb;
  logic [26:0] ma, mb;
  assign ea = (a_q[30:23] == 8'd0) ? 8'd1 : a_q[30:23];
  assign eb = (b_q[30:23] == 8'd0) ? 8'd1 : b_q[30:23];
  assign ma = {(a_q[30:23] != 8'd0), a_q[22:0], 3'b000};
  assign mb = {(b_q[30:23] != 8'd0), b_q[22:0], 3'b000};

  logic        b_bigger;
  logic [7:0]  diff;
  logic [4:0]  diff_clamped;
  assign b_bigger     = {eb, mb} > {ea, ma};
  assign diff         = b_bigger ? (eb - ea) : (ea - eb);
  // Shifting by 27 or more leaves only the sticky bit, so clamping is exact.
  assign diff_clamped = (diff > 8'd27) ? 5'd27 : diff[4:0];

  // Per-cycle shift amount and the mask of the bits it drops.
  logic [4:0]  k;
  logic [26:0] drop_mask;
  assign k         = (rem_q < STEP) ? rem_q : STEP;
  // With k = 27 the shift wraps to 0 and the subtraction gives all ones.
  assign drop_mask = (27'd1 << k) - 27'd1;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    sub_d        = sub_q;
    rem_d        = rem_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    eff_sub_d    = eff_sub_q;
    swapped_d    = swapped_q;
    special_d    = special_q;
    exp_big_d    = exp_big_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          state_d = CMP;
        end
      end
      CMP: begin
        sign_a_d     = a_q[31];
        sign_b_d     = b_q[31];
        eff_sub_d    = a_q[31] ^ b_q[31] ^ sub_q;
        special_d    = (a_q[30:23] == 8'hFF) || (b_q[30:23] == 8'hFF);
        swapped_d    = b_bigger;
        exp_big_d    = b_bigger ? eb : ea;
        mant_big_d   = b_bigger ? mb : ma;
        mant_small_d = b_bigger ? ma : mb;
        rem_d        = diff_clamped;
        state_d      = (diff_clamped == 5'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        // Bit 0 accumulates everything shifted past it (sticky).
        mant_small_d = (mant_small_q >> k)
                     | {26'd0, (|(mant_small_q & drop_mask)) | mant_small_q[0]};
        rem_d        = rem_q - k;
        if (rem_q == k) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      rem_q        <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      eff_sub_q    <= 1'b0;
      swapped_q    <= 1'b0;
      special_q    <= 1'b0;
      exp_big_q    <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sub_q        <= sub_d;
      rem_q        <= rem_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      eff_sub_q    <= eff_sub_d;
      swapped_q    <= swapped_d;
      special_q    <= special_d;
      exp_big_q    <= exp_big_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign sign_a     = sign_a_q;
  assign sign_b     = sign_b_q;
  assign eff_sub    = eff_sub_q;
  assign swapped    = swapped_q;
  assign special    = special_q;
  assign exp_big    = exp_big_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;

endmodule

// File: doc/fp_add_align.md
Name: fp_add_align

Overview:
- Front-end operand pre-alignment stage for the single-precision FP add/sub datapath.
- Accepts two IEEE-754 binary32 operands and an add/sub select.
- Orders the operands by magnitude and right-shifts the smaller significand over several cycles, collecting guard, round and sticky bits.
- Delivers the larger exponent, the aligned significands, both raw signs, the effective operation and a swap flag to the adder and sign/exponent result-selection logic.

Parameters:
- SHIFT_STEP, 1, maximum right-shift positions applied per SHIFT cycle; legal values 1 to 27.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- op_a  in  32  binary32 operand A.
- op_b  in  32  binary32 operand B.
- sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- sign_a  out  1  registered sign of op_a.
- sign_b  out  1  registered sign of op_b (raw, not flipped by sub).
- eff_sub  out  1  sign_a ^ sign_b ^ sub.
- swapped  out  1  1 when B has the larger magnitude.
- exp_big  out  8  effective exponent of the larger-magnitude operand.
- mant_big  out  27  {hidden, frac[22:0], 3'b000} of the larger operand.
- mant_small  out  27  aligned {hidden, frac, G, R, S} of the smaller operand.
- special  out  1  either operand has exponent 8'hFF.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE from any state, including mid-shift; any in-flight pair is discarded.
  - All registered outputs become 0: out_valid=0, sign_a, sign_b, eff_sub, swapped, exp_big, mant_big, mant_small, special.
  - in_ready=1 in the first cycle after reset deasserts.
- Unpack:
  - Exponent 0 gives hidden bit 0 and effective exponent 1 (denormal/zero).
  - Otherwise hidden bit 1 and effective exponent = exponent field.
  - Significand = {hidden, frac, 3'b000}.
- FSM states IDLE, CMP, SHIFT, DONE:
  - IDLE: in_ready=1. When in_valid & in_ready, latch op_a, op_b and sub; go to CMP.
  - CMP (1 cycle), compare {exp, significand}:
    - If B is strictly larger, swap the operands and set swapped=1; equal magnitudes give swapped=0.
    - diff = exp_big - exp_small, clamped to 27.
    - Compute eff_sub and special.
    - Go to DONE if diff=0, else SHIFT.
  - SHIFT:
    - Each cycle shift mant_small right by k = min(SHIFT_STEP, remaining) and decrement remaining by k.
    - New bit0 = OR of all bits shifted out in this step and the old bit0 (sticky is sticky).
    - Go to DONE in the cycle remaining reaches 0.
  - DONE: out_valid=1, all outputs stable. On out_valid & out_ready go to IDLE.
- Latency, counted in edges after the accept edge:
  - out_valid rises after 2 + ceil(diff/SHIFT_STEP) edges.
  - diff=0 gives 2 edges.
- Throughput: one operation in flight. in_ready=0 from accept until the DONE handshake.
- No combinational path from in_valid or out_ready to any output other than the state-derived in_ready.
- Inf/NaN: aligned identically to finite values; special=1 flags downstream override. No exceptions are raised here.
- in_valid while in_ready=0 is ignored and does not corrupt the latched operands.
- out_ready held 0 in DONE: outputs hold indefinitely.

Test Plan:
- SHIFT_STEP=1, op_a=32'h3F800000, op_b=32'h40000000, sub=0:
  - Expect swapped=1, exp_big=8'h80, mant_big=27'h4000000, mant_small=27'h2000000, eff_sub=0.
  - out_valid 3 edges after accept.
- op_a=op_b=32'h3F800000, sub=1:
  - Expect swapped=0, eff_sub=1, mant_small=mant_big=27'h4000000.
  - out_valid 2 edges after accept.
- SHIFT_STEP=4, op_a=32'h3F800000, op_b=32'h33800000 (diff 24):
  - Expect mant_small=27'h0000004.
  - 6 SHIFT cycles; out_valid 8 edges after accept.
- op_a=32'h3F800000, op_b=32'h30800000 (diff 30, clamped to 27):
  - Expect mant_small=27'h0000001 (sticky only).
- op_a=32'h3FC00001, op_b=32'h3E800000 (diff 2):
  - Expect mant_small=27'h1000000.
- Reset and protocol:
  - Assert rst during SHIFT: next cycle out_valid=0, in_ready=1, all outputs 0.
  - A following pair completes with correct values.
  - op_a=32'h7F800000 (Inf), op_b=0 gives special=1.
  - Holding out_ready=0 for 5 cycles keeps outputs frozen.
